fetch_unit: RTL

- IF stage directly upstream of the IF/ID pipeline register.
- Owns the PC and next-PC selection (sequential, branch, jump).
- Runs a req/ready handshake to instruction memory and presents {PC+4, instruction} to IF/ID each cycle.
- Inserts a NOP bubble when memory is slow, holds under hazard stall, and raises the IF/ID flush on redirects.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_pc_next_sel.sv | 30 +++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and helpers for the IF stage
//
// Purpose: bubble encoding, fetch FSM state encoding and the jump-target
// helper shared by fetch_unit and pc_next_sel (and reusable by ID-stage
// branch logic).
package fetch_unit_pkg;

  // Bubble word; must match the IF/ID flush value.
  localparam logic [31:0] NOP_INST = 32'hFC00_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // J-type target: upper nibble of the sequential PC, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] jump_addr);
    return {pc_plus4[31:28], jump_addr, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ready bus
//
// Purpose: groups the instruction-memory handshake.
// Signals:
//   imem_req_o    request from the fetch unit
//   imem_addr_o   request address, stable while req is high and ready is low
//   imem_ready_i  data valid this cycle, completes the request
//   imem_data_i   instruction word
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// rtl/fetch_unit_pc_next_sel.sv - redirect target mux and PC+4 adder
//
// Purpose: purely combinational next-PC helper.
// Ports:
//   pc_i           current PC
//   branch_i       taken branch (wins over jump)
//   branch_addr_i  branch target
//   jump_i         jump decoded
//   jump_addr_i    26-bit jump index
//   pc_plus4_o     pc_i + 4 (wraps modulo 2^32)
//   redirect_o     branch_i | jump_i
//   target_o       redirect target
module pc_next_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [25:0] jump_addr_i,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  assign pc_plus4_o = pc_i + 32'd4;
  assign redirect_o = branch_i | jump_i;
  assign target_o   = branch_i ? branch_addr_i : jump_target(pc_plus4_o, jump_addr_i);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, next-PC selection and imem handshake
//
// Purpose: owns the PC, fetches from instruction memory with a req/ready
// handshake and presents {PC+4, instruction} to the IF/ID register.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   imem           instruction memory bus (fetch_unit_if.master)
//   stall_i        hazard hold (same as IF/ID hd_i)
//   branch_i       taken branch from ID, branch_addr_i its target
//   jump_i         jump from ID, jump_addr_i its 26-bit index
//   inst_addr_o    PC+4 of the presented instruction
//   inst_o         presented instruction, NOP_INST when none
//   valid_o        inst_o is a real instruction
//   flush_o        IF/ID flush on redirect
//   fetch_cnt_o    instructions accepted by IF/ID
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fetch_unit_if.master        imem,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic                jump_i,
  input  logic [25:0]         jump_addr_i,
  output logic [31:0]         inst_addr_o,
  output logic [31:0]         inst_o,
  output logic                valid_o,
  output logic                flush_o,
  output logic [31:0]         fetch_cnt_o
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] hold_buf;
  logic [31:0] hold_addr;
  logic [31:0] fetch_cnt;

  logic [31:0] pc_plus4;
  logic [31:0] req_plus4;
  logic [31:0] target;
  logic        redirect;

  pc_next_sel u_pc_next_sel (
    .pc_i          (pc),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .pc_plus4_o    (pc_plus4),
    .redirect_o    (redirect),
    .target_o      (target)
  );

  assign req_plus4   = req_addr + 32'd4;
  assign fetch_cnt_o = fetch_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_buf  <= NOP_INST;
      hold_addr <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_addr <= pc;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect && imem.imem_ready_i) begin
            pc       <= target;
            req_addr <= target;
          end else if (redirect) begin
            // Memory is mid-transaction: let it finish at the old address.
            pc    <= target;
            state <= ST_DISCARD;
          end else if (imem.imem_ready_i && stall_i) begin
            hold_buf  <= imem.imem_data_i;
            hold_addr <= req_plus4;
            state     <= ST_HOLD;
          end else if (imem.imem_ready_i) begin
            pc        <= req_plus4;
            req_addr  <= req_plus4;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= ST_FETCH;
          end else if (!stall_i) begin
            // pc still equals the held word's address here.
            pc        <= pc_plus4;
            req_addr  <= pc_plus4;
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (redirect) begin
            pc <= target;
          end
          if (imem.imem_ready_i) begin
            req_addr <= redirect ? target : pc;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    imem.imem_req_o  = 1'b0;
    imem.imem_addr_o = req_addr;
    inst_o           = NOP_INST;
    inst_addr_o      = req_plus4;
    valid_o          = 1'b0;
    case (state)
      ST_FETCH: begin
        imem.imem_req_o = 1'b1;
        if (imem.imem_ready_i) begin
          inst_o  = imem.imem_data_i;
          valid_o = 1'b1;
        end
      end
      ST_HOLD: begin
        inst_o      = hold_buf;
        inst_addr_o = hold_addr;
        valid_o     = 1'b1;
      end
      ST_DISCARD: imem.imem_req_o = 1'b1;
      default: ;
    endcase
  end

  // IDLE only occurs in/just after reset, where no redirect is meaningful.
  assign flush_o = redirect && (state != ST_IDLE);

endmodule
